// File: rtl/safe_keypad_scanner.sv
// safe_keypad_scanner
//   Scans a 4x4 active-low matrix keypad, debounces whole-matrix scans,
//   rejects ghosting (more than one intersection down) and delivers each
//   accepted keypress as a 4-bit code over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          scan enable; low halts scanning and releases the rows
//   col_n[3:0]   keypad columns, active-low, asynchronous to clk
//   row_n[3:0]   keypad row drive, active-low one-hot
//   key_code     accepted key {row[1:0], col[1:0]}
//   key_valid    key_code holds an unconsumed key
//   key_ready    consumer takes the key on key_valid && key_ready
//   key_held     debounced key currently down
//   overrun      sticky: a key was dropped because the previous one was unconsumed
//   clr_overrun  synchronous clear of overrun
//
// FSM states
//   state       | meaning
//   IDLE        | no key down, waiting for a single-key scan
//   DEB_PRESS   | same single key seen on cnt consecutive scans
//   PRESSED     | key accepted and still down, no auto-repeat
//   DEB_RELEASE | empty matrix seen on cnt consecutive scans
module safe_keypad_scanner #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N      = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  logic [3:0]    col_s1, col_s2;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    row_idx;
  logic [15:0]   hits_acc;
  logic [15:0]   cur_hits;
  logic [15:0]   hits_all;
  logic [4:0]    hit_cnt;
  logic [3:0]    hit_code;
  logic          dwell_last;
  logic          scan_done;
  logic          scan_none;
  logic          scan_one;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [3:0]    cand, cand_nxt;
  logic          accept;
  logic          drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  assign dwell_last = (dwell_cnt == DWELL_LAST);
  assign scan_done  = ena && dwell_last && (row_idx == 2'd3);

  // Current row's columns placed at bit {row, col} of the 16-key map.
  assign cur_hits = {12'b0, ~col_s2} << {row_idx, 2'b00};
  assign hits_all = hits_acc | cur_hits;

  always_comb begin
    hit_cnt  = '0;
    hit_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits_all[i]) begin
        hit_cnt  = hit_cnt + 5'd1;
        hit_code = 4'(i);
      end
    end
  end

  assign scan_none = (hit_cnt == 5'd0);
  assign scan_one  = (hit_cnt == 5'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
      hits_acc  <= '0;
    end else if (!ena) begin
      dwell_cnt <= '0;
      row_idx   <= '0;
      hits_acc  <= '0;
    end else if (dwell_last) begin
      dwell_cnt <= '0;
      row_idx   <= row_idx + 2'd1;
      hits_acc  <= (row_idx == 2'd3) ? 16'h0000 : (hits_acc | cur_hits);
    end else begin
      dwell_cnt <= dwell_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  // The debounce count saturates at DEB_N once a press or release is taken.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (!ena) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (scan_done) begin
      case (state)
        IDLE: begin
          if (scan_one) begin
            cand_nxt = hit_code;
            if (DEB_N <= 4'd1) begin
              accept    = 1'b1;
              state_nxt = PRESSED;
              cnt_nxt   = DEB_N;
            end else begin
              state_nxt = DEB_PRESS;
              cnt_nxt   = 4'd1;
            end
          end
        end
        DEB_PRESS: begin
          if (scan_one && (hit_code == cand)) begin
            if ((cnt + 4'd1) >= DEB_N) begin
              accept    = 1'b1;
              state_nxt = PRESSED;
              cnt_nxt   = DEB_N;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else if (scan_one) begin
            cand_nxt = hit_code;
            cnt_nxt  = 4'd1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        PRESSED: begin
          if (scan_none) begin
            if (DEB_N <= 4'd1) begin
              state_nxt = IDLE;
              cnt_nxt   = DEB_N;
            end else begin
              state_nxt = DEB_RELEASE;
              cnt_nxt   = 4'd1;
            end
          end
        end
        DEB_RELEASE: begin
          if (scan_none) begin
            if ((cnt + 4'd1) >= DEB_N) begin
              state_nxt = IDLE;
              cnt_nxt   = DEB_N;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A key may be loaded in the same cycle the previous one is consumed.
  assign drop = accept && key_valid && !key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept && !drop) begin
        key_code  <= cand_nxt;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  assign row_n    = ena ? ~(4'b0001 << row_idx) : 4'b1111;
  assign key_held = ena && ((state == PRESSED) || (state == DEB_RELEASE));

endmodule

// File: tb/tb_safe_keypad_scanner.sv
// Testbench for safe_keypad_scanner: an ideal keypad model drives col_n from
// row_n and a set of pressed keys; a scan-level reference model predicts the
// key stream, handshake and flags cycle by cycle.
module tb_safe_keypad_scanner;

  localparam int SD   = 4;
  localparam int DEB  = 2;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       key_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       overrun;

  logic [15:0] pk = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc;
  bit         m_valid;
  logic [3:0] m_code;
  bit         m_ov;
  bit         m_down;
  int         run_len;
  int         rel_len;
  logic [3:0] run_code;
  int         pulses = 0;
  bit         prev_valid = 1'b0;

  safe_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .key_held(key_held), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pk[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic model_reset();
    cyc = 0; m_valid = 0; m_code = 4'h0; m_ov = 0;
    m_down = 0; run_len = 0; rel_len = 0; run_code = 4'h0;
  endtask

  task automatic model_edge();
    bit emit;
    bit drop;
    logic [3:0] ec;
    int n;
    emit = 0; ec = 4'h0;
    if (!ena) begin
      cyc = 0; m_down = 0; run_len = 0; rel_len = 0;
    end else begin
      cyc++;
      if (cyc % SCAN == 0) begin
        n = $countones(pk);
        for (int i = 0; i < 16; i++) if (pk[i]) ec = 4'(i);
        if (!m_down) begin
          if (n == 1) begin
            if (run_len > 0 && ec == run_code) run_len++;
            else begin run_code = ec; run_len = 1; end
            if (run_len >= DEB) begin emit = 1; m_down = 1; run_len = 0; rel_len = 0; end
          end else run_len = 0;
        end else begin
          if (n == 0) begin
            rel_len++;
            if (rel_len >= DEB) begin m_down = 0; rel_len = 0; end
          end else rel_len = 0;
        end
      end
    end
    drop = emit && m_valid && !key_ready;
    if (emit && !drop) begin m_code = ec; m_valid = 1; end
    else if (m_valid && key_ready) m_valid = 0;
    if (drop) m_ov = 1;
    else if (clr_overrun) m_ov = 0;
  endtask

  // Advance n clock cycles, comparing every output with the model each cycle.
  task automatic step(int n);
    logic [3:0] exp_row;
    logic [1:0] er;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      er = 2'((cyc / SD) % 4);
      exp_row = ena ? ~(4'b0001 << er) : 4'b1111;
      n_checks += 5;
      if (row_n !== exp_row) begin n_fail++; $display("FAIL row_n cyc=%0d: got %b want %b", cyc, row_n, exp_row); end
      if (key_valid !== m_valid) begin n_fail++; $display("FAIL key_valid cyc=%0d: got %b want %b", cyc, key_valid, m_valid); end
      if (key_code !== m_code) begin n_fail++; $display("FAIL key_code cyc=%0d: got %h want %h", cyc, key_code, m_code); end
      if (key_held !== (ena && m_down)) begin n_fail++; $display("FAIL key_held cyc=%0d: got %b want %b", cyc, key_held, ena && m_down); end
      if (overrun !== m_ov) begin n_fail++; $display("FAIL overrun cyc=%0d: got %b want %b", cyc, overrun, m_ov); end
      if (key_valid === 1'b1 && !prev_valid) pulses++;
      prev_valid = (key_valid === 1'b1);
    end
  endtask

  task automatic scans(int n);
    step(n * SCAN);
  endtask

  task automatic align();
    while (cyc % SCAN != 0) step(1);
  endtask

  task automatic test_reset(int pre);
    step(pre);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (row_n !== 4'b1110) begin n_fail++; $display("FAIL rst_row_n: got %b want 1110", row_n); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rst_key_valid: got %b want 0", key_valid); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL rst_key_held: got %b want 0", key_held); end
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL rst_key_code: got %h want 0", key_code); end
    pk = 16'h0000; key_ready = 1'b0; clr_overrun = 1'b0; ena = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    prev_valid = 1'b0;
  endtask

  task automatic test_single_key();
    key_ready = 1'b0;
    pk = 16'h0200;
    scans(1);
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", key_valid); end
    scans(1);
    n_checks += 2;
    if (key_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", key_valid); end
    if (key_code !== 4'h9) begin n_fail++; $display("FAIL single_code: got %h want 9", key_code); end
    scans(3);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL single_consume: got %b want 0", key_valid); end
    align();
    pk = 16'h0000;
    scans(3);
  endtask

  task automatic test_bounce();
    int p0;
    logic [3:0] k;
    p0 = pulses;
    k = 4'($urandom_range(0, 15));
    for (int i = 0; i < 10; i++) begin
      pk = (i % 2 == 0) ? (16'h0001 << k) : 16'h0000;
      scans(1);
    end
    pk = 16'h0000;
    scans(2);
    n_checks++;
    if (pulses - p0 != 0) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 0", pulses - p0); end
  endtask

  task automatic test_ghost();
    pk = 16'h0021;
    scans(6);
    n_checks += 2;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL ghost_held: got %b want 0", key_held); end
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL ghost_valid: got %b want 0", key_valid); end
    pk = 16'h0001;
    scans(2);
    n_checks += 2;
    if (key_valid !== 1'b1) begin n_fail++; $display("FAIL ghost_after_valid: got %b want 1", key_valid); end
    if (key_code !== 4'h0) begin n_fail++; $display("FAIL ghost_after_code: got %h want 0", key_code); end
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    align();
    pk = 16'h0000;
    scans(3);
  endtask

  task automatic test_overrun();
    key_ready = 1'b0;
    pk = 16'h0020; scans(3);
    pk = 16'h0000; scans(3);
    pk = 16'h0040; scans(3);
    pk = 16'h0000; scans(3);
    n_checks += 2;
    if (key_code !== 4'h5) begin n_fail++; $display("FAIL ovr_code: got %h want 5", key_code); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    n_checks += 2;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    if (key_code !== 4'h5) begin n_fail++; $display("FAIL ovr_code_kept: got %h want 5", key_code); end
    align();
    pk = 16'h0080; scans(3);
    pk = 16'h0000; scans(3);
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_again: got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    int p0;
    key_ready = 1'b1;
    p0 = pulses;
    pk = 16'h8000; scans(20);
    n_checks++;
    if (pulses - p0 != 1) begin n_fail++; $display("FAIL b2b_first: got %0d want 1", pulses - p0); end
    pk = 16'h0000; scans(2);
    pk = 16'h8000; scans(3);
    n_checks++;
    if (pulses - p0 != 2) begin n_fail++; $display("FAIL b2b_second: got %0d want 2", pulses - p0); end
    step(5);
    ena = 1'b0;
    step(1);
    n_checks += 2;
    if (row_n !== 4'b1111) begin n_fail++; $display("FAIL ena_row_n: got %b want 1111", row_n); end
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL ena_key_held: got %b want 0", key_held); end
    step(3);
    pk = 16'h0000;
    ena = 1'b1;
    scans(3);
    key_ready = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    int dur;
    int a;
    int b;
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case (sel)
        0: pk = 16'h0000;
        3: pk = (16'h0001 << a) | (16'h0001 << b);
        default: pk = 16'h0001 << a;
      endcase
      dur = $urandom_range(1, 4);
      for (int c = 0; c < dur * SCAN; c++) begin
        key_ready   = ($urandom_range(0, 3) == 0);
        clr_overrun = ($urandom_range(0, 31) == 0);
        step(1);
      end
    end
    key_ready = 1'b0;
    clr_overrun = 1'b0;
    pk = 16'h0000;
    scans(3);
  endtask

  initial begin
    model_reset();
    test_reset(0);
    test_single_key();
    test_bounce();
    test_ghost();
    test_overrun();
    test_reset(9);
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/safe_keypad_scanner.md
Name: safe_keypad_scanner

Overview:
Front-end key-entry source for the Safe ASIC top. It scans a 4x4 active-low matrix keypad wired to the dedicated pins, debounces the keypad, and rejects ghosting. Each accepted keypress is delivered as a 4-bit digit over a valid/ready handshake to the combination-lock core. The block drives rows from `uo_out` bits, reads columns from `ui_in` bits, and produces the key stream that the lock core consumes.

Parameters:
SCAN_DIV, 16, clock cycles each row stays driven (2..256)
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release (1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low = scanning halted
col_n  input  4  keypad columns, active-low, externally pulled up, asynchronous
row_n  output  4  keypad row drive, active-low one-hot
key_code  output  4  accepted key, encoded as {row[1:0], col[1:0]}
key_valid  output  1  key_code holds an unconsumed key
key_ready  input  1  consumer accepts the key on key_valid && key_ready
key_held  output  1  debounced key currently down
overrun  output  1  sticky flag: a key was dropped because the previous one was unconsumed
clr_overrun  input  1  synchronous clear of overrun

Behaviour:
- Reset values (async, on rst_n low):
  - row_n=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0.
  - Dwell counter=0, row index=0, FSM=IDLE, debounce count=0.
- col_n synchroniser:
  - Two-flop synchroniser on col_n; all logic uses the synchronised value.
  - Scan timing below is stated relative to the synchronised value.
- Row scan:
  - Row index r drives row_n = ~(1<<r) for SCAN_DIV cycles.
  - Columns are sampled on the last cycle of each dwell.
  - r then advances 0→1→2→3→0.
  - One full scan = 4*SCAN_DIV cycles.
- Scan result, evaluated after row 3 is sampled:
  - NONE: no column low in any row.
  - ONE(code): exactly one row/column intersection low.
  - MULTI: two or more intersections low, treated as ghosting.
- FSM:
  - IDLE:
    - ONE(c) → DEB_PRESS with cand=c, cnt=1.
    - Otherwise stay.
  - DEB_PRESS:
    - ONE(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS: accept, go to PRESSED.
    - ONE(other) → cand=other, cnt=1.
    - NONE or MULTI → IDLE.
    - With DEBOUNCE_SCANS=1, acceptance happens directly on the IDLE scan.
  - PRESSED:
    - key_held=1.
    - NONE → DEB_RELEASE with cnt=1.
    - ONE(any) or MULTI → stay. No auto-repeat.
  - DEB_RELEASE:
    - NONE → cnt+1. When cnt reaches DEBOUNCE_SCANS: go to IDLE, key_held=0.
    - Any key seen → back to PRESSED, cnt cleared.
- Accept action, in the cycle after the final scan sample:
  - If key_valid=0, or key_valid && key_ready in the same cycle: key_code=cand, key_valid=1.
  - Otherwise the new key is dropped, key_code is unchanged, and overrun=1.
- Handshake:
  - key_valid stays high and key_code stays stable until key_valid && key_ready.
  - key_valid clears on the next edge unless a simultaneous accept reloads it.
  - key_ready while key_valid=0 has no effect.
- overrun:
  - Set by a drop, cleared by clr_overrun.
  - A simultaneous set and clear leaves overrun=1.
- ena=0:
  - row_n=4'b1111; dwell counter, row index, FSM and cnt go to their reset values on the next edge.
  - key_held=0.
  - key_valid and key_code are held, and the handshake still completes.
  - overrun is held.
  - When ena returns to 1, the scan restarts at row 0.
- Reset mid-scan: everything returns to reset values immediately; a pending key is lost.
- Counters:
  - The dwell counter is $clog2(SCAN_DIV) bits and wraps at SCAN_DIV-1.
  - The debounce count is 4 bits and saturates at DEBOUNCE_SCANS.

Test Plan:
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2 (scan = 16 cycles).
1. Assert rst_n low mid-dwell at row 2 → row_n=4'b1110, key_valid=0, overrun=0 asynchronously. After release, row 1 is driven exactly 4 cycles later.
2. Hold the row-2/column-1 key for 5 scans with key_ready=0 → key_code=4'h9 and key_valid=1 after the 2nd complete scan containing the key. Pulse key_ready once → key_valid drops the next cycle.
3. Make col_n bounce so the key is present on alternate scans for 10 scans → key_valid never rises; FSM cycles between IDLE and DEB_PRESS.
4. Press keys 4'h0 and 4'h5 together for 6 scans → no key_valid, key_held=0. Release 4'h5 while keeping 4'h0 down → key_valid with key_code=4'h0.
5. Overrun: with key_ready=0, press/release 4'h5, then press/release 4'h6 → key_code stays 4'h5 and overrun=1. clr_overrun → overrun=0 and key_code still 4'h5.
6. Hold 4'hF for 20 scans with key_ready=1 → exactly one key_valid pulse. Release for 2 scans, then press 4'hF again → a second pulse. Drop ena mid-press → row_n=4'b1111 and key_held=0.
